gate_enable_seq: RTL

Synchronous enable sequencer driving the active-low enable input (`notE`) of the NAND2-based clock-gating `chip`. It converts a request/length handshake into a clean enable window of exactly N gated clock cycles, enforces lead-in and guard spacing between windows, and reports completion. It sits in the clock domain of the free-running `clk` (from `clock_gen`), upstream of the gate.

---
 rtl/gate_seq_pkg.sv | 20 ++
 rtl/seq_down_counter.sv | 36 +++
 rtl/gate_enable_seq.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/gate_seq_pkg.sv
// rtl/gate_seq_pkg.sv - shared state encoding and parameter defaults for the enable sequencer
package gate_seq_pkg;

  localparam int DEF_CNT_W = 8;
  localparam int DEF_LEAD  = 1;
  localparam int DEF_GUARD = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LEAD,
    S_ON,
    S_GUARD
  } seq_state_e;

  // Counter preload for a phase of `cycles` edges whose first `bias` edges are spent elsewhere.
  function automatic int preload(int cycles, int bias);
    return (cycles > bias) ? cycles - bias : 0;
  endfunction

endpackage

// File: rtl/seq_down_counter.sv
// rtl/seq_down_counter.sv - loadable down-counter that saturates at zero and flags terminal count
module seq_down_counter
  import gate_seq_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             tc
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == '0);

endmodule

// File: rtl/gate_enable_seq.sv
// rtl/gate_enable_seq.sv - request/length to enable-window sequencer driving the clock gate's notE
module gate_enable_seq
  import gate_seq_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int LEAD  = DEF_LEAD,
  parameter int GUARD = DEF_GUARD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [CNT_W-1:0] len,
  input  logic             abort,
  output logic             ack,
  output logic             notE,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  // The done edge is the first guard cycle, so the GUARD state itself spans GUARD-1 edges.
  localparam logic [CNT_W-1:0] LEAD_LD  = CNT_W'(preload(LEAD, 1));
  localparam logic [CNT_W-1:0] GUARD_LD = CNT_W'(preload(GUARD, 2));

  seq_state_e       state_q, state_d;
  logic             ack_q, ack_d;
  logic             not_e_q, not_e_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             end_win;
  logic             len_load, len_dec, len_tc;
  logic             tmr_load, tmr_dec, tmr_tc;
  logic [CNT_W-1:0] tmr_val;

  seq_down_counter #(.CNT_W(CNT_W)) u_len_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (len_load),
    .load_val (len),
    .dec      (len_dec),
    .tc       (len_tc)
  );

  // Lead-in and guard never overlap, so one timer serves both.
  seq_down_counter #(.CNT_W(CNT_W)) u_tmr_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .tc       (tmr_tc)
  );

  always_comb begin
    state_d   = state_q;
    ack_d     = 1'b0;
    not_e_d   = 1'b1;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    end_win   = 1'b0;
    len_load  = 1'b0;
    len_dec   = 1'b0;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    tmr_val   = LEAD_LD;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          ack_d = 1'b1;
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            len_load = 1'b1;
            if (LEAD == 0) begin
              state_d = S_ON;
            end else begin
              state_d  = S_LEAD;
              tmr_load = 1'b1;
            end
          end
        end
      end
      S_LEAD: begin
        if (abort) begin
          end_win   = 1'b1;
          aborted_d = 1'b1;
        end else if (tmr_tc) begin
          state_d = S_ON;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      S_ON: begin
        // An exhausted count wins over a coincident abort.
        if (len_tc) begin
          end_win = 1'b1;
        end else if (abort) begin
          end_win   = 1'b1;
          aborted_d = 1'b1;
        end else begin
          not_e_d = 1'b0;
          len_dec = 1'b1;
        end
      end
      S_GUARD: begin
        if (tmr_tc) begin
          state_d = S_IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (end_win) begin
      done_d = 1'b1;
      if (GUARD > 1) begin
        state_d  = S_GUARD;
        tmr_load = 1'b1;
        tmr_val  = GUARD_LD;
      end else begin
        state_d = S_IDLE;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ack_q     <= 1'b0;
      not_e_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      not_e_q   <= not_e_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign ack     = ack_q;
  assign notE    = not_e_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign aborted = aborted_q;

endmodule
